spmm_row_feeder: RTL and testbench

//  Drives one sparse-dot-product PE in the SPMM stage. Loads a W column, packs streamed CSR

---
 rtl/spmm_row_feeder.sv | 188 ++++++++++++++++++
 tb/tb_spmm_row_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spmm_row_feeder.sv
// Row feeder for one sparse dot-product PE: loads a W column, packs the CSR nonzeros of
// one H row into PE vectors, dispatches them once and returns the PE result tagged with its row.
module spmm_row_feeder #(
    parameter int DATA_WIDTH       = 8,
    parameter int DOT_PRODUCT_SIZE = 5,
    parameter int ROW_IDX_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES   = 16,
    localparam int COL_IDX_WIDTH   = $clog2(DOT_PRODUCT_SIZE),
    localparam int NODE_INFO_WIDTH = COL_IDX_WIDTH + 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      w_valid_i,
    input  logic [DATA_WIDTH-1:0]                     w_data_i,
    output logic                                      w_ready_o,
    input  logic                                      w_reload_i,
    input  logic                                      h_valid_i,
    input  logic [COL_IDX_WIDTH-1:0]                  h_col_idx_i,
    input  logic [DATA_WIDTH-1:0]                     h_value_i,
    input  logic                                      h_last_i,
    input  logic                                      h_row_last_i,
    output logic                                      h_ready_o,
    output logic                                      pe_valid_o,
    output logic [COL_IDX_WIDTH*DOT_PRODUCT_SIZE-1:0] col_idx_o,
    output logic [DATA_WIDTH*DOT_PRODUCT_SIZE-1:0]    value_o,
    output logic [NODE_INFO_WIDTH-1:0]                node_info_o,
    output logic [DATA_WIDTH*DOT_PRODUCT_SIZE-1:0]    weight_o,
    input  logic                                      pe_ready_i,
    input  logic [DATA_WIDTH-1:0]                     pe_result_i,
    output logic                                      res_valid_o,
    output logic [DATA_WIDTH-1:0]                     res_data_o,
    output logic [ROW_IDX_WIDTH-1:0]                  res_row_o,
    output logic                                      res_last_o,
    output logic                                      err_o,
    output logic [1:0]                                dbg_state_o
);
    localparam int DW  = DATA_WIDTH;
    localparam int DPS = DOT_PRODUCT_SIZE;
    localparam int CIW = COL_IDX_WIDTH;
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CIW-1:0] W_LAST   = CIW'(DPS - 1);
    localparam logic [CIW-1:0] NNZ_FULL = CIW'(DPS);
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD_W  = 2'd0,
        S_COLLECT = 2'd1,
        S_ISSUE   = 2'd2,
        S_WAIT    = 2'd3
    } state_e;

    state_e                 state_q;
    logic [CIW-1:0]         w_cnt_q;
    logic [CIW-1:0]         nnz_q;
    logic                   row_last_q;
    logic [ROW_IDX_WIDTH-1:0] row_tag_q;
    logic                   reload_pend_q;
    logic [TW-1:0]          timer_q;
    logic                   pe_valid_q;
    logic                   res_valid_q;
    logic [DW-1:0]          res_data_q;
    logic [ROW_IDX_WIDTH-1:0] res_row_q;
    logic                   res_last_q;
    logic                   err_q;
    logic [DW-1:0]          weight_q [DPS];
    logic [CIW-1:0]         col_q    [DPS];
    logic [DW-1:0]          val_q    [DPS];

    logic reload_now;
    logic row_done;

    // Valid/ready: a W or H beat transfers only in a cycle where both valid and ready are high;
    // ready is never conditioned on valid, and a pending reload masks h_ready_o for that cycle.
    assign reload_now = (state_q == S_COLLECT) && (nnz_q == '0) && (reload_pend_q || w_reload_i);
    assign row_done   = (state_q == S_WAIT) && (pe_ready_i || (timer_q == T_LAST));
    assign w_ready_o  = (state_q == S_LOAD_W);
    assign h_ready_o  = (state_q == S_COLLECT) && !reload_now;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_LOAD_W;
            w_cnt_q       <= '0;
            nnz_q         <= '0;
            row_last_q    <= 1'b0;
            row_tag_q     <= '0;
            reload_pend_q <= 1'b0;
            timer_q       <= '0;
            pe_valid_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_row_q     <= '0;
            res_last_q    <= 1'b0;
            err_q         <= 1'b0;
            for (int i = 0; i < DPS; i++) begin
                weight_q[i] <= '0;
                col_q[i]    <= '0;
                val_q[i]    <= '0;
            end
        end else begin
            pe_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            if (w_reload_i) reload_pend_q <= 1'b1;
            case (state_q)
                S_LOAD_W: begin
                    if (w_valid_i) begin
                        weight_q[w_cnt_q] <= w_data_i;
                        if (w_cnt_q == W_LAST) begin
                            w_cnt_q <= '0;
                            state_q <= S_COLLECT;
                        end else begin
                            w_cnt_q <= w_cnt_q + 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (reload_now) begin
                        reload_pend_q <= 1'b0;
                        w_cnt_q       <= '0;
                        state_q       <= S_LOAD_W;
                    end else if (h_valid_i) begin
                        // Beats beyond the vector length are dropped but still flag the error.
                        if (nnz_q < NNZ_FULL) begin
                            col_q[nnz_q] <= h_col_idx_i;
                            val_q[nnz_q] <= h_value_i;
                            nnz_q        <= nnz_q + 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (h_last_i) begin
                            row_last_q <= h_row_last_i;
                            pe_valid_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (pe_ready_i) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= pe_result_i;
                        res_row_q   <= row_tag_q;
                        res_last_q  <= row_last_q;
                        row_tag_q   <= row_last_q ? '0 : row_tag_q + 1'b1;
                    end else if (timer_q == T_LAST) begin
                        err_q     <= 1'b1;
                        row_tag_q <= row_tag_q + 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= S_LOAD_W;
            endcase
            if (row_done) begin
                nnz_q      <= '0;
                row_last_q <= 1'b0;
                state_q    <= S_COLLECT;
                for (int i = 0; i < DPS; i++) begin
                    col_q[i] <= '0;
                    val_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        col_idx_o = '0;
        value_o   = '0;
        weight_o  = '0;
        for (int i = 0; i < DPS; i++) begin
            col_idx_o[i*CIW +: CIW] = col_q[i];
            value_o[i*DW +: DW]     = val_q[i];
            weight_o[i*DW +: DW]    = weight_q[i];
        end
    end

    assign node_info_o = {nnz_q, row_last_q};
    assign pe_valid_o  = pe_valid_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_row_o   = res_row_q;
    assign res_last_o  = res_last_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spmm_row_feeder.sv
// Directed bench for spmm_row_feeder: W load, row packing, PE handshake, overflow,
// watchdog timeout, deferred and immediate reload, and reset in the middle of a row.
module tb_spmm_row_feeder;
    localparam int DW  = 8;
    localparam int DPS = 5;
    localparam int CIW = 3;
    localparam int NIW = 4;
    localparam int RIW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 w_valid_i = 1'b0;
    logic [DW-1:0]        w_data_i = '0;
    logic                 w_ready_o;
    logic                 w_reload_i = 1'b0;
    logic                 h_valid_i = 1'b0;
    logic [CIW-1:0]       h_col_idx_i = '0;
    logic [DW-1:0]        h_value_i = '0;
    logic                 h_last_i = 1'b0;
    logic                 h_row_last_i = 1'b0;
    logic                 h_ready_o;
    logic                 pe_valid_o;
    logic [CIW*DPS-1:0]   col_idx_o;
    logic [DW*DPS-1:0]    value_o;
    logic [NIW-1:0]       node_info_o;
    logic [DW*DPS-1:0]    weight_o;
    logic                 pe_ready_i = 1'b0;
    logic [DW-1:0]        pe_result_i = '0;
    logic                 res_valid_o;
    logic [DW-1:0]        res_data_o;
    logic [RIW-1:0]       res_row_o;
    logic                 res_last_o;
    logic                 err_o;
    logic [1:0]           dbg_state_o;

    int n_checks = 0;
    int n_bad    = 0;
    logic [DW-1:0] exp_q[$];

    spmm_row_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o), .w_reload_i(w_reload_i),
        .h_valid_i(h_valid_i), .h_col_idx_i(h_col_idx_i), .h_value_i(h_value_i),
        .h_last_i(h_last_i), .h_row_last_i(h_row_last_i), .h_ready_o(h_ready_o),
        .pe_valid_o(pe_valid_o), .col_idx_o(col_idx_o), .value_o(value_o),
        .node_info_o(node_info_o), .weight_o(weight_o),
        .pe_ready_i(pe_ready_i), .pe_result_i(pe_result_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_row_o(res_row_o),
        .res_last_o(res_last_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_w(input logic [DW*DPS-1:0] w);
        for (int i = 0; i < DPS; i++) begin
            w_valid_i = 1'b1;
            w_data_i  = w[i*DW +: DW];
            @(negedge clk);
        end
        w_valid_i = 1'b0;
        w_data_i  = '0;
    endtask

    task automatic send_beat(input logic [CIW-1:0] c, input logic [DW-1:0] v,
                             input logic last, input logic rlast);
        h_valid_i    = 1'b1;
        h_col_idx_i  = c;
        h_value_i    = v;
        h_last_i     = last;
        h_row_last_i = rlast;
        @(negedge clk);
        h_valid_i    = 1'b0;
        h_last_i     = 1'b0;
        h_row_last_i = 1'b0;
    endtask

    task automatic pe_respond(input int delay, input logic [DW-1:0] r);
        exp_q.push_back(r);
        repeat (delay) @(negedge clk);
        pe_ready_i  = 1'b1;
        pe_result_i = r;
        @(negedge clk);
        pe_ready_i  = 1'b0;
        pe_result_i = '0;
    endtask

    task automatic check_result(input string tag, input logic [RIW-1:0] row, input logic last);
        logic [DW-1:0] exp_data;
        exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_valid"}, res_valid_o, 1'b1);
        check({tag, "_data"}, res_data_o, exp_data);
        check({tag, "_row"}, res_row_o, row);
        check({tag, "_last"}, res_last_o, last);
        @(negedge clk);
        check({tag, "_pulse"}, res_valid_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   cnt;
        logic saw_res;
        logic err_mid;

        repeat (3) @(negedge clk);
        check("rst_w_ready", w_ready_o, 1'b1);
        check("rst_h_ready", h_ready_o, 1'b0);
        check("rst_pe_valid", pe_valid_o, 1'b0);
        check("rst_res_valid", res_valid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_res_row", res_row_o, 0);
        check("rst_weight", weight_o, 0);
        check("rst_state", dbg_state_o, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load_w(40'h05_04_03_02_01);
        check("w1_weight", weight_o, 40'h0504030201);
        check("w1_h_ready", h_ready_o, 1'b1);
        check("w1_w_ready", w_ready_o, 1'b0);

        send_beat(3'd0, 8'd2, 1'b0, 1'b0);
        send_beat(3'd3, 8'd1, 1'b1, 1'b0);
        check("r0_pe_valid", pe_valid_o, 1'b1);
        check("r0_node_info", node_info_o, 4'b0100);
        check("r0_col_idx", col_idx_o, 15'h0018);
        check("r0_value", value_o, 40'h0000000102);
        @(negedge clk);
        check("r0_pe_valid_1cyc", pe_valid_o, 1'b0);
        check("r0_h_ready_wait", h_ready_o, 1'b0);
        check("r0_state_wait", dbg_state_o, 2'd3);
        pe_respond(2, 8'h06);
        check("r0_h_ready_back", h_ready_o, 1'b1);
        check_result("r0", 8'd0, 1'b0);

        send_beat(3'd1, 8'd7, 1'b0, 1'b0);
        send_beat(3'd4, 8'd9, 1'b1, 1'b1);
        check("r1_pe_valid", pe_valid_o, 1'b1);
        check("r1_node_info", node_info_o, 4'b0101);
        check("r1_col_idx", col_idx_o, 15'h0021);
        check("r1_value", value_o, 40'h0000000907);
        @(negedge clk);
        pe_respond(1, 8'h3C);
        check_result("r1", 8'd1, 1'b1);

        send_beat(3'd2, 8'd5, 1'b1, 1'b0);
        check("to_pe_valid", pe_valid_o, 1'b1);
        cnt = 0;
        saw_res = 1'b0;
        err_mid = 1'bx;
        while (!h_ready_o && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (res_valid_o) saw_res = 1'b1;
            if (cnt == 16) err_mid = err_o;
        end
        check("to_cycles", cnt, 17);
        check("to_err_before", err_mid, 1'b0);
        check("to_err", err_o, 1'b1);
        check("to_no_result", saw_res, 1'b0);

        send_beat(3'd0, 8'd3, 1'b1, 1'b0);
        check("rl_pe_valid", pe_valid_o, 1'b1);
        @(negedge clk);
        w_reload_i = 1'b1;
        @(negedge clk);
        w_reload_i = 1'b0;
        check("rl_weight_held", weight_o, 40'h0504030201);
        check("rl_w_ready_wait", w_ready_o, 1'b0);
        check("rl_state_wait", dbg_state_o, 2'd3);
        pe_respond(1, 8'h44);
        check("rl_h_ready_blocked", h_ready_o, 1'b0);
        check("rl_w_ready_collect", w_ready_o, 1'b0);
        check_result("rl", 8'd1, 1'b0);
        check("rl_w_ready", w_ready_o, 1'b1);
        check("rl_h_ready", h_ready_o, 1'b0);
        load_w(40'h05_06_07_08_09);
        check("rl_weight_new", weight_o, 40'h0506070809);
        check("rl_h_ready_after", h_ready_o, 1'b1);

        send_beat(3'd1, 8'd4, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pe_ready_i  = 1'b1;
        pe_result_i = 8'h77;
        @(negedge clk);
        pe_ready_i  = 1'b0;
        pe_result_i = '0;
        check("mr_res_valid", res_valid_o, 1'b0);
        check("mr_state", dbg_state_o, 2'd0);
        check("mr_w_ready", w_ready_o, 1'b1);
        check("mr_res_row", res_row_o, 0);
        check("mr_res_data", res_data_o, 0);
        check("mr_err", err_o, 1'b0);
        check("mr_weight", weight_o, 0);
        @(negedge clk);
        check("mr_res_valid_late", res_valid_o, 1'b0);

        load_w(40'h05_04_03_02_01);
        for (int i = 0; i < DPS; i++) begin
            send_beat(CIW'(i), 8'h11 + DW'(i), 1'b0, 1'b0);
        end
        check("ov_err_before", err_o, 1'b0);
        check("ov_h_ready_full", h_ready_o, 1'b1);
        send_beat(3'd2, 8'h16, 1'b1, 1'b0);
        check("ov_pe_valid", pe_valid_o, 1'b1);
        check("ov_err", err_o, 1'b1);
        check("ov_node_info", node_info_o, 4'b1010);
        check("ov_value", value_o, 40'h1514131211);
        check("ov_col_idx", col_idx_o, 15'h4688);
        @(negedge clk);
        pe_respond(1, 8'h20);
        check_result("ov", 8'd0, 1'b0);

        w_reload_i  = 1'b1;
        h_valid_i   = 1'b1;
        h_col_idx_i = 3'd1;
        h_value_i   = 8'h55;
        h_last_i    = 1'b1;
        #1;
        check("ir_h_ready", h_ready_o, 1'b0);
        @(negedge clk);
        w_reload_i = 1'b0;
        h_valid_i  = 1'b0;
        h_last_i   = 1'b0;
        check("ir_w_ready", w_ready_o, 1'b1);
        check("ir_pe_valid", pe_valid_o, 1'b0);
        check("ir_node_info", node_info_o, 4'b0000);
        check("ir_err_sticky", err_o, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
